// File: rtl/pc_sequencer.sv
// Program counter owner and next-PC sequencer for the fetch stage.
// Optional MIPS delay-slot behaviour is enabled with `define BRANCH_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter int unsigned           N_BITS   = 32,
  parameter logic [N_BITS-1:0]     RESET_PC = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic              jr_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       jaddr_i,
  input  logic [N_BITS-1:0] rs_i,
  output logic [N_BITS-1:0] pc_o,
  output logic [N_BITS-1:0] pc_plus4_o,
  output logic              redirect_o,
  output logic              misalign_o,
  output logic              busy_o
);

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {RUN = 1'b0, DELAY = 1'b1} state_t;
`else
  typedef enum logic {RUN = 1'b0} state_t;
`endif

  state_t            state_q, state_d;
  logic [N_BITS-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              misalign_q, misalign_d;
  logic [N_BITS-1:0] branch_target;
  logic [N_BITS-1:0] jump_target;
  logic [N_BITS-1:0] jr_target;
  logic [N_BITS-1:0] target;
  logic              adv;
  logic              redirect_req;
  logic              jr_misalign;

`ifdef BRANCH_DELAY_SLOT_EN
  logic [N_BITS-1:0] pending_q, pending_d;
`endif

  assign adv          = instr_valid_i & ~stall_i;
  assign pc_plus4_o   = pc_q + N_BITS'(4);
  assign branch_target = pc_plus4_o + {{(N_BITS-18){imm_i[15]}}, imm_i, 2'b00};
  assign jump_target  = {pc_plus4_o[N_BITS-1:28], jaddr_i, 2'b00};
  assign jr_target    = {rs_i[N_BITS-1:2], 2'b00};
  assign redirect_req = jr_i | jump_i | branch_taken_i;
  assign jr_misalign  = jr_i & (rs_i[1:0] != 2'b00);

  always_comb begin
    target = pc_plus4_o;
    if (jr_i)                target = jr_target;
    else if (jump_i)         target = jump_target;
    else if (branch_taken_i) target = branch_target;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pending_d  = pending_q;
`endif
    if (adv) begin
      case (state_q)
        RUN: begin
          if (redirect_req) begin
`ifdef BRANCH_DELAY_SLOT_EN
            // Delay slot executes first; the target waits in pending.
            pc_d       = pc_plus4_o;
            pending_d  = target;
            misalign_d = jr_misalign;
            state_d    = DELAY;
`else
            pc_d       = target;
            redirect_d = 1'b1;
            misalign_d = jr_misalign;
`endif
          end else begin
            pc_d = pc_plus4_o;
          end
        end
`ifdef BRANCH_DELAY_SLOT_EN
        DELAY: begin
          pc_d       = pending_q;
          redirect_d = 1'b1;
          state_d    = RUN;
        end
`endif
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end
  assign busy_o = (state_q == DELAY);
`else
  assign busy_o = 1'b0;
`endif

  assign pc_o       = pc_q;
  assign redirect_o = redirect_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// checked against a transaction-level next-PC model.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, instr_valid_i, stall_i, branch_taken_i, jump_i, jr_i;
  logic [15:0] imm_i;
  logic [25:0] jaddr_i;
  logic [31:0] rs_i;
  logic [31:0] pc_o, pc_plus4_o;
  logic        redirect_o, misalign_o, busy_o;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_pend;
  logic        m_delay, m_redir, m_mis;

  pc_sequencer #(.N_BITS(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .jump_i(jump_i), .jr_i(jr_i),
    .imm_i(imm_i), .jaddr_i(jaddr_i), .rs_i(rs_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .redirect_o(redirect_o),
    .misalign_o(misalign_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the model, then sample 1ns after the edge.
  task automatic drive(input logic rst, input logic v, input logic s,
                       input logic b, input logic j, input logic r,
                       input logic [15:0] imm, input logic [25:0] ja,
                       input logic [31:0] rs);
    logic [31:0] tgt, p4;
    reset = rst; instr_valid_i = v; stall_i = s;
    branch_taken_i = b; jump_i = j; jr_i = r;
    imm_i = imm; jaddr_i = ja; rs_i = rs;
    p4 = m_pc + 32'd4;
    if (r)      tgt = rs & 32'hFFFF_FFFC;
    else if (j) tgt = (p4 & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
    else        tgt = p4 + $unsigned(32'($signed(imm)) * 32'd4);
    if (rst) begin
      m_pc = RST_PC; m_delay = 0; m_redir = 0; m_mis = 0;
    end else if (!(v && !s)) begin
      m_redir = 0; m_mis = 0;
    end else begin
`ifdef BRANCH_DELAY_SLOT_EN
      if (m_delay) begin
        m_pc = m_pend; m_redir = 1; m_mis = 0; m_delay = 0;
      end else if (b || j || r) begin
        m_pend = tgt; m_pc = p4; m_delay = 1; m_redir = 0;
        m_mis = r && (rs[1:0] != 2'b00);
      end else begin
        m_pc = p4; m_redir = 0; m_mis = 0;
      end
`else
      m_pc = (b || j || r) ? tgt : p4;
      m_redir = b || j || r;
      m_mis = r && (rs[1:0] != 2'b00);
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic test_reset;
    drive(1, 1, 0, 1, 1, 0, 16'h1234, 26'h3ABCDEF, 32'h1);
    drive(1, 1, 0, 0, 1, 1, 16'h0, 26'h0, 32'h3);
    checks++;
    if ({pc_o, redirect_o, misalign_o, busy_o} !== {RST_PC, 3'b000}) begin
      errors++;
      $display("FAIL reset pc=%h r=%b m=%b b=%b want pc=%h 000", pc_o, redirect_o, misalign_o, busy_o, RST_PC);
    end
    for (int i = 1; i <= 2; i++) begin
      idle(1);
      checks++;
      if (pc_o !== RST_PC + 32'(4 * i) || redirect_o !== 1'b0) begin
        errors++;
        $display("FAIL seq%0d pc=%h r=%b want %h 0", i, pc_o, redirect_o, RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch;
    idle(2); // pc = 0x00400010
    drive(0, 1, 0, 1, 0, 0, 16'hFFFC, 26'h0, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    checks++;
    if (pc_o !== 32'h0040_0014 || busy_o !== 1'b1 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL branch_slot pc=%h busy=%b r=%b want 00400014 1 0", pc_o, busy_o, redirect_o);
    end
    idle(1);
`endif
    checks++;
    if (pc_o !== 32'h0040_0004 || redirect_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL branch pc=%h r=%b busy=%b want 00400004 1 0", pc_o, redirect_o, busy_o);
    end
    idle(1);
    checks++;
    if (redirect_o !== 1'b0) begin
      errors++; $display("FAIL branch_pulse redirect=%b want 0", redirect_o);
    end
  endtask

  task automatic test_jump;
    drive(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    idle(8); // pc = 0x00400020
    drive(0, 1, 0, 1, 1, 0, 16'h0040, 26'h0100000, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    idle(1);
`endif
    checks++;
    if (pc_o !== 32'h0040_0000 || redirect_o !== 1'b1) begin
      errors++; $display("FAIL jump pc=%h r=%b want 00400000 1", pc_o, redirect_o);
    end
    drive(0, 1, 0, 1, 1, 1, 16'h0001, 26'h0000010, 32'h0040_0033);
    checks++;
    if (misalign_o !== 1'b1) begin
      errors++; $display("FAIL jr_misalign got %b want 1", misalign_o);
    end
`ifdef BRANCH_DELAY_SLOT_EN
    idle(1);
`endif
    checks++;
    if (pc_o !== 32'h0040_0030 || redirect_o !== 1'b1) begin
      errors++; $display("FAIL jr pc=%h r=%b want 00400030 1", pc_o, redirect_o);
    end
    idle(1);
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++; $display("FAIL jr_misalign_pulse got %b want 0", misalign_o);
    end
  endtask

  task automatic test_stall;
    logic [31:0] frozen;
    int redirs;
    frozen = pc_o;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 1, 0, 16'h0, 26'h0000040, 32'h0);
      checks++;
      if (pc_o !== frozen || redirect_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d pc=%h r=%b busy=%b want %h 0 0", i, pc_o, redirect_o, busy_o, frozen);
      end
    end
    redirs = 0;
    drive(0, 1, 0, 0, 1, 0, 16'h0, 26'h0000040, 32'h0);
    redirs += int'(redirect_o);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      redirs += int'(redirect_o);
    end
    checks++;
    if (redirs != 1 || pc_o !== m_pc) begin
      errors++; $display("FAIL stall_release redirects=%0d pc=%h want 1 %h", redirs, pc_o, m_pc);
    end
    frozen = pc_o;
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 1, 1, 16'h5, 26'h5, 32'h8);
    checks++;
    if (pc_o !== frozen || redirect_o !== 1'b0) begin
      errors++; $display("FAIL invalid_hold pc=%h r=%b want %h 0", pc_o, redirect_o, frozen);
    end
  endtask

  task automatic test_wrap;
    drive(0, 1, 0, 0, 0, 1, 16'h0, 26'h0, 32'hFFFF_FFFC);
`ifdef BRANCH_DELAY_SLOT_EN
    idle(1);
`endif
    idle(1);
    checks++;
    if (pc_o !== 32'h0000_0000 || pc_plus4_o !== 32'h0000_0004) begin
      errors++; $display("FAIL wrap_seq pc=%h p4=%h want 00000000 00000004", pc_o, pc_plus4_o);
    end
    drive(0, 1, 0, 0, 0, 1, 16'h0, 26'h0, 32'hFFFF_FFF8);
`ifdef BRANCH_DELAY_SLOT_EN
    idle(1);
`endif
    drive(0, 1, 0, 1, 0, 0, 16'h0001, 26'h0, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    idle(1);
`endif
    checks++;
    if (pc_o !== 32'h0000_0000 || redirect_o !== 1'b1) begin
      errors++; $display("FAIL wrap_branch pc=%h r=%b want 00000000 1", pc_o, redirect_o);
    end
  endtask

  task automatic test_delay_reset;
`ifdef BRANCH_DELAY_SLOT_EN
    drive(0, 1, 0, 0, 1, 0, 16'h0, 26'h0000777, 32'h0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL delay_enter busy=%b want 1", busy_o);
    end
    drive(1, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    checks++;
    if (pc_o !== RST_PC || busy_o !== 1'b0) begin
      errors++; $display("FAIL delay_reset pc=%h busy=%b want %h 0", pc_o, busy_o, RST_PC);
    end
    idle(1);
    checks++;
    if (pc_o !== RST_PC + 32'd4 || redirect_o !== 1'b0) begin
      errors++; $display("FAIL delay_discard pc=%h r=%b want %h 0", pc_o, redirect_o, RST_PC + 32'd4);
    end
`else
    drive(0, 1, 0, 0, 1, 0, 16'h0, 26'h0000777, 32'h0);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL busy_idle busy=%b want 0", busy_o);
    end
    drive(1, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
`endif
  endtask

  task automatic test_random;
    logic v, s, b, j, r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 99) == 0), v, s, b, j, r,
            16'($urandom), 26'($urandom), $urandom);
      checks++;
      if ({pc_o, pc_plus4_o, redirect_o, misalign_o, busy_o} !==
          {m_pc, m_pc + 32'd4, m_redir, m_mis, m_delay}) begin
        errors++;
        $display("FAIL random%0d pc=%h p4=%h r=%b m=%b b=%b want %h %h %b %b %b", i,
                 pc_o, pc_plus4_o, redirect_o, misalign_o, busy_o,
                 m_pc, m_pc + 32'd4, m_redir, m_mis, m_delay);
      end
    end
  endtask

  initial begin
    m_pc = RST_PC; m_pend = '0; m_delay = 0; m_redir = 0; m_mis = 0;
    reset = 1; instr_valid_i = 0; stall_i = 0; branch_taken_i = 0;
    jump_i = 0; jr_i = 0; imm_i = '0; jaddr_i = '0; rs_i = '0;
    test_reset;
    test_branch;
    test_jump;
    test_stall;
    test_wrap;
    test_delay_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
